// File: rtl/jtag_cmd_decoder.sv
// Decodes JTAG register-bank command words into single bus transfers, then reports status.
// Optional bus-wait timeout is enabled by defining JTAG_CMD_TIMEOUT_EN.
module jtag_cmd_decoder #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  iMAIN_CLK,
  input  logic                  iRESET_N,
  input  logic [WIDTH-1:0]      iCMD,
  input  logic [WIDTH-1:0]      iWDATA,
  output logic [WIDTH-1:0]      oSTATUS,
  output logic [WIDTH-1:0]      oRDATA,
  output logic                  oBUS_REQ,
  output logic                  oBUS_WE,
  output logic [ADDR_WIDTH-1:0] oBUS_ADDR,
  output logic [WIDTH-1:0]      oBUS_WDATA,
  input  logic                  iBUS_ACK,
  input  logic [WIDTH-1:0]      iBUS_RDATA
);

  if (WIDTH < 32 || ADDR_WIDTH < 1 || ADDR_WIDTH > 16 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("jtag_cmd_decoder: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      cmd_prev_q, cmd_prev_d;
  logic [7:0]            last_tag_q, last_tag_d;
  logic [7:0]            tag_q, tag_d;
  logic [1:0]            op_q, op_d;
  logic                  busy_q, busy_d;
  logic [1:0]            result_q, result_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
`ifdef JTAG_CMD_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
`endif

  always_ff @(posedge iMAIN_CLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state_q    <= IDLE;
      cmd_prev_q <= '0;
      last_tag_q <= '0;
      tag_q      <= '0;
      op_q       <= '0;
      busy_q     <= 1'b0;
      result_q   <= '0;
      rdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef JTAG_CMD_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_prev_q <= cmd_prev_d;
      last_tag_q <= last_tag_d;
      tag_q      <= tag_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      result_q   <= result_d;
      rdata_q    <= rdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef JTAG_CMD_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_prev_d = iCMD;
    last_tag_d = last_tag_q;
    tag_d      = tag_q;
    op_d       = op_q;
    busy_d     = busy_q;
    result_d   = result_q;
    rdata_d    = rdata_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef JTAG_CMD_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Stability filter: word must match the previous clock's sample.
        if (iCMD == cmd_prev_q && iCMD[31:24] != last_tag_q) begin
          tag_d   = iCMD[31:24];
          op_d    = iCMD[23:22];
          addr_d  = iCMD[ADDR_WIDTH-1:0];
          wdata_d = iWDATA;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        unique case (op_q)
          2'b01, 2'b10: begin
            req_d   = 1'b1;
            we_d    = (op_q == 2'b01);
            state_d = WAIT_ACK;
`ifdef JTAG_CMD_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
          2'b00: begin
            result_d = 2'b00;
            state_d  = DONE;
          end
          default: begin
            result_d = 2'b10;
            state_d  = DONE;
          end
        endcase
      end
      WAIT_ACK: begin
        // ACK takes priority so an ACK on the expiry clock is a success.
        if (iBUS_ACK) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          result_d = 2'b00;
          if (!we_q) rdata_d = iBUS_RDATA;
          state_d  = DONE;
        end
`ifdef JTAG_CMD_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          result_d = 2'b01;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        last_tag_d = tag_q;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oSTATUS        = '0;
    oSTATUS[31:24] = last_tag_q;
    oSTATUS[2]     = busy_q;
    oSTATUS[1:0]   = result_q;
  end

  assign oRDATA     = rdata_q;
  assign oBUS_REQ   = req_q;
  assign oBUS_WE    = we_q;
  assign oBUS_ADDR  = addr_q;
  assign oBUS_WDATA = wdata_q;

endmodule

// File: tb/tb_jtag_cmd_decoder.sv
// Directed + randomized bench for jtag_cmd_decoder against a transaction-level model.
// Define JTAG_CMD_TIMEOUT_EN on both files to exercise the timeout path.
module tb_jtag_cmd_decoder;
  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic [31:0] cmd, wdata, status, rdata, bus_wdata, bus_rdata;
  logic        req, we, ack;
  logic [15:0] addr;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: what the host should see after each completed command.
  logic [7:0]  m_last_tag;
  logic [1:0]  m_result;
  logic [31:0] m_rdata;

  jtag_cmd_decoder #(.WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .iMAIN_CLK (clk),
    .iRESET_N  (rst_n),
    .iCMD      (cmd),
    .iWDATA    (wdata),
    .oSTATUS   (status),
    .oRDATA    (rdata),
    .oBUS_REQ  (req),
    .oBUS_WE   (we),
    .oBUS_ADDR (addr),
    .oBUS_WDATA(bus_wdata),
    .iBUS_ACK  (ack),
    .iBUS_RDATA(bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {m_last_tag, 22'd0, m_result};
  endfunction

  // Apply one command word and play the bus slave; ack after ack_dly clocks of REQ.
  task automatic do_cmd(input logic [31:0] c, input logic [31:0] wd,
                        input int unsigned ack_dly, input logic [31:0] rd);
    logic [7:0] tag;
    logic [1:0] op;
    bit exec, bus;
    tag  = c[31:24];
    op   = c[23:22];
    exec = (tag != m_last_tag);
    bus  = exec && (op == 2'b01 || op == 2'b10);
    cmd   = c;
    wdata = wd;
    tick();
    tick();
    chk("req_early", {63'd0, req}, 64'd0);
    wdata = $urandom;
    tick();
    chk("req_latency", {63'd0, req}, {63'd0, bus});
    if (bus) begin
      chk("bus_we", {63'd0, we}, {63'd0, op == 2'b01});
      chk("bus_addr", {48'd0, addr}, {48'd0, c[15:0]});
      chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, wd});
      chk("busy", {63'd0, status[2]}, 64'd1);
      for (int unsigned i = 0; i < ack_dly; i++) begin
        tick();
        chk("req_hold", {63'd0, req}, 64'd1);
      end
      ack = 1'b1;
      bus_rdata = rd;
      tick();
      ack = 1'b0;
      bus_rdata = $urandom;
      chk("req_drop", {63'd0, req}, 64'd0);
      if (op == 2'b10) m_rdata = rd;
      m_result = 2'b00;
    end else if (exec) begin
      m_result = (op == 2'b11) ? 2'b10 : 2'b00;
    end
    if (exec) m_last_tag = tag;
    tick();
    chk("status", {32'd0, status}, {32'd0, exp_status()});
    chk("rdata", {32'd0, rdata}, {32'd0, m_rdata});
    chk("req_idle", {63'd0, req}, 64'd0);
  endtask

  initial begin
    logic [31:0] c, c2, rd;
    logic [7:0]  t;
    rst_n = 1'b0;
    cmd = '0; wdata = '0; ack = 1'b0; bus_rdata = '0;
    m_last_tag = '0; m_result = '0; m_rdata = '0;
    tick(); tick();
    chk("rst_status", {32'd0, status}, 64'd0);
    chk("rst_req", {62'd0, req, we}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_addr_wdata", {16'd0, addr, bus_wdata}, 64'd0);
    rst_n = 1'b1;
    tick();

    do_cmd(32'h01400010, 32'hDEADBEEF, 2, 32'h0);
    chk("w_status", {32'd0, status}, 64'h01000000);
    do_cmd(32'h02800020, 32'h0, 1, 32'h12345678);
    chk("r_status", {32'd0, status}, 64'h02000000);
    chk("r_rdata", {32'd0, rdata}, 64'h12345678);
    do_cmd(32'h03C00000, 32'h0, 0, 32'h0);
    chk("bad_status", {32'd0, status}, 64'h03000002);
    do_cmd(32'h03C00000, 32'h0, 0, 32'h0);
    chk("bad_rerun", {32'd0, status}, 64'h03000002);

    // Read never acknowledged.
    cmd = 32'h04800040;
    tick(); tick(); tick();
    chk("noack_req", {63'd0, req}, 64'd1);
`ifdef JTAG_CMD_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick();
      chk("to_hold", {63'd0, req}, 64'd1);
    end
    tick();
    chk("to_drop", {63'd0, req}, 64'd0);
    m_result = 2'b01;
`else
    repeat (20) tick();
    chk("noack_wait", {63'd0, req}, 64'd1);
    ack = 1'b1; bus_rdata = 32'hA5A5_0001;
    tick();
    ack = 1'b0;
    m_rdata = 32'hA5A5_0001;
    m_result = 2'b00;
`endif
    m_last_tag = 8'h04;
    tick();
    chk("noack_status", {32'd0, status}, {32'd0, exp_status()});
    chk("noack_rdata", {32'd0, rdata}, {32'd0, m_rdata});

    // ACK while idle must be ignored.
    ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    tick();
    ack = 1'b0;
    tick();
    chk("spur_rdata", {32'd0, rdata}, {32'd0, m_rdata});
    chk("spur_status", {32'd0, status}, {32'd0, exp_status()});

    // Command change while busy runs after the current one completes.
    cmd = 32'h05800050;
    tick(); tick(); tick();
    chk("busy_a_req", {63'd0, req}, 64'd1);
    cmd = 32'h06400060; wdata = 32'hCAFE_F00D;
    tick(); tick();
    chk("busy_a_addr", {48'd0, addr}, 64'h0050);
    ack = 1'b1; bus_rdata = 32'h0BAD_CAFE;
    tick();
    ack = 1'b0;
    m_rdata = 32'h0BAD_CAFE; m_last_tag = 8'h05;
    tick(); tick();
    wdata = $urandom;
    tick();
    chk("busy_b_req", {63'd0, req}, 64'd1);
    chk("busy_b_addr", {48'd0, addr}, 64'h0060);
    chk("busy_b_wdata", {32'd0, bus_wdata}, 64'hCAFE_F00D);
    chk("busy_b_we", {63'd0, we}, 64'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    m_last_tag = 8'h06; m_result = 2'b00;
    chk("busy_status", {32'd0, status}, {32'd0, exp_status()});
    chk("busy_rdata", {32'd0, rdata}, {32'd0, m_rdata});

    // Alternating words never pass the stability filter.
    c  = 32'h07400070;
    c2 = 32'h08400080;
    for (int i = 0; i < 10; i++) begin
      cmd = (i % 2 == 0) ? c : c2;
      tick();
      chk("toggle_req", {63'd0, req}, 64'd0);
    end
    cmd = {m_last_tag, 24'h400000};
    repeat (4) tick();
    chk("toggle_status", {32'd0, status}, {32'd0, exp_status()});

    // Reset during WAIT_ACK clears outputs without waiting for a clock.
    cmd = 32'h09800090;
    tick(); tick(); tick();
    chk("mid_req", {63'd0, req}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {62'd0, req, we}, 64'd0);
    chk("mid_rst_status", {32'd0, status}, 64'd0);
    chk("mid_rst_rdata", {32'd0, rdata}, 64'd0);
    chk("mid_rst_bus", {16'd0, addr, bus_wdata}, 64'd0);
    cmd = '0;
    tick(); tick();
    rst_n = 1'b1;
    m_last_tag = '0; m_result = '0; m_rdata = '0;
    tick();
    do_cmd(32'h00400010, 32'h1111_2222, 0, 32'h0);
    chk("tag0_status", {32'd0, status}, 64'd0);

    // Randomized commands against the model.
    for (int i = 0; i < 24; i++) begin
      t  = ($urandom_range(0, 4) == 0) ? m_last_tag : m_last_tag + 8'($urandom_range(1, 200));
      c  = {t, 2'($urandom_range(0, 3)), 6'($urandom), 16'($urandom)};
      rd = $urandom;
      do_cmd(c, $urandom, $urandom_range(0, TO - 1), rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
